fwd_scoreboard_u: RTL and testbench

Parametrised forwarding and hazard unit that replaces the fixed two-stage EX/MEM compare with a registered scoreboard of in-flight register writers. Each issued instruction's destination, write enable and result-ready stage enter a shift register that advances with the pipeline and honours stall, freeze and flush. From this state the block produces a per-source forward select for any number of ID-stage operands and a load-use stall request. A saturating counter records hazard stall cycles for performance monitoring.

---
 rtl/fwd_scoreboard_u.sv | 94 +++++++++
 tb/tb_fwd_scoreboard_u.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard_u.sv
// Forwarding/hazard unit built on a shift register of in-flight register writers.
// Produces per-source forward selects, a load-use stall and a saturating stall counter.
module fwd_scoreboard_u #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int REG_AW  = 5,
    parameter int SEL_W   = $clog2(DEPTH + 1),
    parameter int CNT_W   = 16,
    parameter int STG_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue_valid,
    input  logic                       issue_wr_n,
    input  logic [REG_AW-1:0]          issue_rd,
    input  logic [STG_W-1:0]           issue_rdy_stg,
    input  logic [NUM_SRC*REG_AW-1:0]  rs,
    input  logic [NUM_SRC-1:0]         rs_used,
    input  logic                       freeze,
    input  logic                       flush,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       hazard_stall,
    output logic [CNT_W-1:0]           stall_cycles
);

    logic [DEPTH-1:0]  v;
    logic [REG_AW-1:0] rd     [DEPTH];
    logic [STG_W-1:0]  rs_stg [DEPTH];

    logic [NUM_SRC-1:0] stall_req;
    logic [REG_AW-1:0]  src;
    logic               found;
    logic               issue_take;

    // Handshake: the ID instruction is accepted into entry 0 on a rising edge
    // when issue_valid && !hazard_stall && !flush && !freeze; otherwise entry 0
    // receives a bubble (or holds, under freeze).
    assign issue_take = issue_valid && !hazard_stall && !flush && !issue_wr_n
                        && (issue_rd != '0);

    always_comb begin
        fwd_sel   = '0;
        stall_req = '0;
        src       = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src   = rs[k*REG_AW +: REG_AW];
            found = 1'b0;
            // Scan youngest first so older writers of the same register are shadowed.
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && rs_used[k] && (src != '0) && v[i] && (rd[i] == src)) begin
                    found = 1'b1;
                    if (i >= int'(rs_stg[i]))
                        fwd_sel[k*SEL_W +: SEL_W] = SEL_W'(i + 1);
                    else
                        stall_req[k] = 1'b1;
                end
            end
        end
    end

    assign hazard_stall = (|stall_req) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd[i]     <= '0;
                rs_stg[i] <= '0;
            end
        end else if (freeze) begin
            // A flushed ID instruction must not survive a frozen cycle in entry 0.
            if (flush)
                v[0] <= 1'b0;
        end else begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                v[i]      <= v[i-1];
                rd[i]     <= rd[i-1];
                rs_stg[i] <= rs_stg[i-1];
            end
            v[0]      <= issue_take;
            rd[0]     <= issue_take ? issue_rd : '0;
            rs_stg[0] <= issue_take ? issue_rdy_stg : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (hazard_stall && !freeze && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_fwd_scoreboard_u.sv
// Directed bench for fwd_scoreboard_u; a second instance with a 2-bit counter
// exercises stall counter saturation alongside the main instance.
module tb_fwd_scoreboard_u;

    logic       clk;
    logic       rst_n;
    logic       issue_valid;
    logic       issue_wr_n;
    logic [4:0] issue_rd;
    logic [1:0] issue_rdy_stg;
    logic [9:0] rs;
    logic [1:0] rs_used;
    logic       freeze;
    logic       flush;
    logic [3:0] fwd_sel;
    logic       hazard_stall;
    logic [15:0] stall_cycles;
    logic [3:0] sat_fwd_sel;
    logic       sat_hazard_stall;
    logic [1:0] sat_stall_cycles;

    int checks   = 0;
    int failures = 0;

    // {sel1, sel0, hazard_stall}
    logic [4:0] exp_q[$];

    fwd_scoreboard_u dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wr_n(issue_wr_n),
        .issue_rd(issue_rd), .issue_rdy_stg(issue_rdy_stg), .rs(rs), .rs_used(rs_used),
        .freeze(freeze), .flush(flush), .fwd_sel(fwd_sel), .hazard_stall(hazard_stall),
        .stall_cycles(stall_cycles)
    );

    fwd_scoreboard_u #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wr_n(issue_wr_n),
        .issue_rd(issue_rd), .issue_rdy_stg(issue_rdy_stg), .rs(rs), .rs_used(rs_used),
        .freeze(freeze), .flush(flush), .fwd_sel(sat_fwd_sel), .hazard_stall(sat_hazard_stall),
        .stall_cycles(sat_stall_cycles)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of ID-stage stimulus, queue the expected outputs, then
    // pop and compare once the combinational outputs have settled.
    task automatic step(input string tag, input logic iv, input logic wn,
                        input logic [4:0] ird, input logic [1:0] stg,
                        input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] used,
                        input logic frz, input logic fl,
                        input logic [1:0] e0, input logic [1:0] e1, input logic es);
        logic [4:0] exp;
        @(negedge clk);
        issue_valid   = iv;
        issue_wr_n    = wn;
        issue_rd      = ird;
        issue_rdy_stg = stg;
        rs            = {r1, r0};
        rs_used       = used;
        freeze        = frz;
        flush         = fl;
        exp_q.push_back({e1, e0, es});
        #1;
        exp = exp_q.pop_front();
        chk(tag, {27'd0, fwd_sel, hazard_stall}, {27'd0, exp});
        chk({tag, "_sat"}, {27'd0, sat_fwd_sel, sat_hazard_stall}, {27'd0, exp});
    endtask

    task automatic check_cnt(input string tag, input int exp);
        chk({tag, "_cnt"}, {16'd0, stall_cycles}, 32'(exp));
        chk({tag, "_cnt_sat"}, {30'd0, sat_stall_cycles}, (exp > 3) ? 32'd3 : 32'(exp));
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; issue_valid = 0; issue_wr_n = 1; issue_rd = 0; issue_rdy_stg = 0;
        rs = 0; rs_used = 0; freeze = 0; flush = 0;
        #1;
        chk("reset_sel", {28'd0, fwd_sel}, 32'd0);
        chk("reset_stall", {31'd0, hazard_stall}, 32'd0);
        check_cnt("reset", 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU back-to-back: x5 forwarded from EX, MEM, WB, then register file
        step("alu_issue", 1, 0, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step("alu_ex",    0, 1, 0, 0, 5, 0, 2'b01, 0, 0, 1, 0, 0);
        step("alu_mem",   0, 1, 0, 0, 5, 0, 2'b01, 0, 0, 2, 0, 0);
        step("alu_wb",    0, 1, 0, 0, 5, 0, 2'b01, 0, 0, 3, 0, 0);
        step("alu_rf",    0, 1, 0, 0, 5, 0, 2'b01, 0, 0, 0, 0, 0);
        check_cnt("alu", 0);

        // Load-use on source 1
        step("ld_issue",  1, 0, 7, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step("ld_stall",  1, 1, 0, 0, 0, 7, 2'b10, 0, 0, 0, 0, 1);
        step("ld_fwd",    1, 1, 0, 0, 0, 7, 2'b10, 0, 0, 0, 2, 0);
        check_cnt("ld", 1);
        idle("ld_idle");

        // Youngest writer wins
        step("yw_issue0", 1, 0, 3, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step("yw_issue1", 1, 0, 3, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step("yw_both",   1, 0, 0, 0, 3, 3, 2'b11, 0, 0, 1, 1, 0);
        step("x0_rs0",    0, 1, 0, 0, 0, 3, 2'b11, 0, 0, 0, 2, 0);

        // Unused sources neither forward nor stall
        step("nu_load",   1, 0, 9, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step("nu_check",  0, 1, 0, 0, 9, 9, 2'b00, 0, 0, 0, 0, 0);
        idle("nu_idle");

        // Freeze holds entries
        step("fz_issue",  1, 0, 4, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step("fz_1",      1, 0, 8, 0, 4, 0, 2'b01, 1, 0, 1, 0, 0);
        step("fz_2",      1, 0, 8, 0, 4, 0, 2'b01, 1, 0, 1, 0, 0);
        step("fz_3",      1, 0, 8, 0, 4, 0, 2'b01, 1, 0, 1, 0, 0);
        step("fz_after",  0, 1, 0, 0, 4, 0, 2'b01, 0, 0, 1, 0, 0);
        step("fz_shift",  0, 1, 0, 0, 4, 0, 2'b01, 0, 0, 2, 0, 0);

        // Freeze with a hazard: stall held, counter frozen
        step("fs_load",   1, 0, 6, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step("fs_frz",    1, 1, 0, 0, 6, 0, 2'b01, 1, 0, 0, 0, 1);
        check_cnt("fs_frz", 1);
        step("fs_run",    1, 1, 0, 0, 6, 0, 2'b01, 0, 0, 0, 0, 1);
        step("fs_fwd",    0, 1, 0, 0, 6, 0, 2'b01, 0, 0, 2, 0, 0);
        check_cnt("fs", 2);

        // Flush kills the ID instruction and masks the stall
        step("fl_issue",  1, 0, 10, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0);
        step("fl_check",  0, 1, 0, 0, 10, 0, 2'b01, 0, 0, 0, 0, 0);
        step("fl_load",   1, 0, 11, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step("fl_mask",   1, 1, 0, 0, 11, 0, 2'b01, 0, 1, 0, 0, 0);
        step("fl_fwd",    0, 1, 0, 0, 11, 0, 2'b01, 0, 0, 2, 0, 0);
        check_cnt("fl", 2);

        // Two more stalls: 2-bit counter saturates at 3
        step("sat_ld0",   1, 0, 12, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step("sat_st0",   1, 1, 0, 0, 0, 12, 2'b10, 0, 0, 0, 0, 1);
        step("sat_fwd0",  0, 1, 0, 0, 0, 12, 2'b10, 0, 0, 0, 2, 0);
        check_cnt("sat0", 3);
        step("sat_ld1",   1, 0, 13, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step("sat_st1",   1, 1, 0, 0, 13, 0, 2'b01, 0, 0, 0, 0, 1);
        step("rst_load",  1, 0, 14, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        check_cnt("sat1", 4);

        // Reset asserted mid-stall clears outputs before the next edge
        step("rst_stall", 1, 1, 0, 0, 14, 0, 2'b01, 0, 0, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sel", {28'd0, fwd_sel}, 32'd0);
        chk("rst_mid_stall", {31'd0, hazard_stall}, 32'd0);
        check_cnt("rst_mid", 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_issue", 1, 0, 15, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        step("post_fwd",   0, 1, 0, 0, 15, 0, 2'b01, 0, 0, 1, 0, 0);
        check_cnt("post", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
